// File: rtl/cpu_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cpu_control
// Description : Hack CPU control block. It accepts one instruction at a time
//               through an IDLE -> EXEC (-> WB) sequence, drives an external
//               ALU, and issues data-memory writes and program-counter updates.
// Revision    : 1.0  initial release
// ============================================================================
module cpu_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] inM,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_ctrl,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic [15:0] outM,
    output logic        writeM,
    output logic [14:0] addressM,
    output logic [14:0] pc
);

    localparam logic [14:0] C_PC_STEP = 15'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [15:0] r_q, r_d;
    logic        z_q, z_d;
    logic        n_q, n_d;
    logic [14:0] pc_q, pc_d;

    logic [14:0] w_pc_inc;
    logic        w_jump;

    // 15-bit add wraps 7FFF -> 0000 naturally.
    assign w_pc_inc = pc_q + C_PC_STEP;
    assign w_jump   = (ir_q[2] & n_q) | (ir_q[1] & z_q) | (ir_q[0] & ~n_q & ~z_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ir_q    <= 16'h0000;
            a_q     <= 16'h0000;
            d_q     <= 16'h0000;
            r_q     <= 16'h0000;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            pc_q    <= 15'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            d_q     <= d_d;
            r_q     <= r_d;
            z_q     <= z_d;
            n_q     <= n_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        a_d         = a_q;
        d_d         = d_q;
        r_d         = r_q;
        z_d         = z_q;
        n_d         = n_q;
        pc_d        = pc_q;
        instr_ready = 1'b0;
        alu_ctrl    = 6'b000000;
        outM        = 16'h0000;
        writeM      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                instr_ready = ~reset;
                if (instr_valid && !reset) begin
                    ir_d    = instr;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (ir_q[15]) begin
                    alu_ctrl = ir_q[11:6];
                    r_d      = alu_out;
                    z_d      = alu_zr;
                    n_d      = alu_ng;
                    state_d  = ST_WB;
                end else begin
                    a_d     = {1'b0, ir_q[14:0]};
                    pc_d    = w_pc_inc;
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                outM   = r_q;
                // Gated by reset so an abort drops the strobe without a clock edge.
                writeM = ir_q[3] & ~reset;
                if (ir_q[5]) a_d = r_q;
                if (ir_q[4]) d_d = r_q;
                // Jump target uses A before this instruction's own A write.
                pc_d    = w_jump ? a_q[14:0] : w_pc_inc;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign alu_x    = d_q;
    assign alu_y    = ir_q[12] ? inM : a_q;
    assign addressM = a_q[14:0];
    assign pc       = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cpu_control
// Description : Randomized scoreboard bench for cpu_control with a Hack-level
//               instruction model, external ALU and data-memory models.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] inM;
    logic [15:0] alu_x, alu_y;
    logic [5:0]  alu_ctrl;
    logic [15:0] alu_out;
    logic        alu_zr, alu_ng;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic [14:0] pc;

    int checks   = 0;
    int failures = 0;

    cpu_control dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .inM        (inM),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out),
        .alu_zr     (alu_zr),
        .alu_ng     (alu_ng),
        .outM       (outM),
        .writeM     (writeM),
        .addressM   (addressM),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return o;
    endfunction

    assign alu_out = hack_alu(alu_x, alu_y, alu_ctrl);
    assign alu_zr  = (alu_out == 16'h0000);
    assign alu_ng  = alu_out[15];

    // Data memory seen by the DUT
    logic [15:0] dev_mem [0:32767];
    assign inM = dev_mem[addressM];

    initial begin
        forever begin
            @(posedge clk);
            if (writeM === 1'b1) dev_mem[addressM] = outM;
        end
    end

    // Reference machine state
    logic [15:0] m_a, m_d;
    logic [14:0] m_pc;
    logic [15:0] m_mem [0:32767];
    bit          model_on;
    bit          mon_en;

    typedef struct {
        int          lat;
        logic [14:0] pc;
        logic [14:0] addr;
        logic [15:0] d;
    } done_t;

    typedef struct {
        logic [15:0] data;
        logic [14:0] addr;
    } wr_t;

    done_t doneq[$];
    wr_t   wrq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_exec(input logic [15:0] ins);
        done_t       e;
        wr_t         w;
        logic [15:0] y, res;
        logic [14:0] a_old;
        logic        jmp;
        if (!ins[15]) begin
            m_a   = {1'b0, ins[14:0]};
            m_pc  = m_pc + 15'd1;
            e.lat = 2;
        end else begin
            a_old = m_a[14:0];
            y     = ins[12] ? m_mem[a_old] : m_a;
            res   = hack_alu(m_d, y, ins[11:6]);
            jmp   = (ins[2] && ($signed(res) < 0)) || (ins[1] && (res == 16'h0000)) ||
                    (ins[0] && ($signed(res) > 0));
            if (ins[3]) begin
                w.data = res;
                w.addr = a_old;
                wrq.push_back(w);
                m_mem[a_old] = res;
            end
            if (ins[5]) m_a = res;
            if (ins[4]) m_d = res;
            m_pc  = jmp ? a_old : m_pc + 15'd1;
            e.lat = 3;
        end
        e.pc   = m_pc;
        e.addr = m_a[14:0];
        e.d    = m_d;
        doneq.push_back(e);
    endtask

    // Offers ins until accepted, then keeps a stray valid instruction on the bus.
    task automatic issue(input logic [15:0] ins);
        int g;
        instr       = ins;
        instr_valid = 1'b1;
        g = 0;
        @(negedge clk);
        while (!instr_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!instr_ready) chk("accept_timeout", 32'(instr_ready), 32'd1);
        if (model_on) model_exec(ins);
        @(posedge clk);
        #1;
        instr       = 16'($urandom);
        instr_valid = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_idle();
        int g;
        instr_valid = 1'b0;
        g = 0;
        @(negedge clk);
        while (!instr_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!instr_ready) chk("idle_timeout", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: write strobes and instruction completions
    bit    busy;
    int    busy_cnt;
    done_t mon_e;
    wr_t   mon_w;

    initial begin
        busy     = 1'b0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!mon_en || reset) begin
                busy = 1'b0;
            end else begin
                if (writeM) begin
                    if (wrq.size() == 0) begin
                        chk("writeM_unexpected", 32'(writeM), 32'd0);
                    end else begin
                        mon_w = wrq.pop_front();
                        chk("outM", 32'(outM), 32'(mon_w.data));
                        chk("addressM_write", 32'(addressM), 32'(mon_w.addr));
                    end
                end
                if (busy) begin
                    busy_cnt++;
                    if (instr_ready) begin
                        busy = 1'b0;
                        if (doneq.size() == 0) begin
                            chk("completion_unexpected", 32'(doneq.size()), 32'd1);
                        end else begin
                            mon_e = doneq.pop_front();
                            chk("latency", 32'(busy_cnt), 32'(mon_e.lat));
                            chk("pc", 32'(pc), 32'(mon_e.pc));
                            chk("A_reg", 32'(addressM), 32'(mon_e.addr));
                            chk("D_reg", 32'(alu_x), 32'(mon_e.d));
                        end
                    end else if (busy_cnt > 8) begin
                        chk("completion_timeout", 32'(busy_cnt), 32'd3);
                        busy = 1'b0;
                    end
                end
                if (instr_ready && instr_valid) begin
                    busy     = 1'b1;
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ins;
        logic [15:0] v;
        logic [14:0] p;
        logic [14:0] ab_addr;
        logic [15:0] ab_data;
        int          rdy_cycles;
        int          g;

        reset       = 1'b1;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        mon_en      = 1'b0;
        model_on    = 1'b1;
        m_a  = 16'h0000;
        m_d  = 16'h0000;
        m_pc = 15'h0000;
        for (int i = 0; i < 32768; i++) begin
            v = 16'($urandom);
            dev_mem[i] = v;
            m_mem[i]   = v;
        end

        #12;
        chk("rst_instr_ready", 32'(instr_ready), 32'd0);
        chk("rst_writeM", 32'(writeM), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_outM", 32'(outM), 32'd0);
        chk("rst_A", 32'(addressM), 32'd0);
        chk("rst_D", 32'(alu_x), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Directed program: A/D load, memory write, unconditional and untaken jumps
        issue(16'h0005);
        issue(16'hEC10);
        issue(16'hE7C8);
        issue(16'h000A);
        issue(16'hEA87);
        issue(16'hEA90);
        issue(16'h0000);
        issue(16'hE301);
        wait_idle();
        chk("dir_pc_after_jgt", 32'(pc), 32'd13);
        chk("dir_mem5", 32'(dev_mem[5]), 32'h0006);

        // Idle with no valid: nothing may move
        p = pc;
        rdy_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_ready) rdy_cycles++;
        end
        chk("idle_ready_cycles", 32'(rdy_cycles), 32'd10);
        chk("idle_pc_stable", 32'(pc), 32'(p));
        @(posedge clk);
        #1;

        // pc wrap
        issue(16'h7FFF);
        issue(16'hEA87);
        wait_idle();
        chk("pc_at_max", 32'(pc), 32'h7FFF);
        issue(16'h0001);
        wait_idle();
        chk("pc_wrap", 32'(pc), 32'd0);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                instr_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 2) == 0)
                ins = {1'b0, ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 31))};
            else
                ins = {3'b111, 13'($urandom)};
            issue(ins);
        end
        wait_idle();
        chk("rand_doneq_empty", 32'(doneq.size()), 32'd0);
        chk("rand_wrq_empty", 32'(wrq.size()), 32'd0);

        // Reset during WB of a memory write aborts it
        mon_en   = 1'b0;
        model_on = 1'b0;
        ab_addr  = addressM;
        ab_data  = dev_mem[ab_addr];
        issue(16'hE7C8);
        instr_valid = 1'b0;
        g = 0;
        @(negedge clk);
        while (!writeM && g < 5) begin
            @(negedge clk);
            g++;
        end
        chk("abort_wb_writeM", 32'(writeM), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_writeM_comb", 32'(writeM), 32'd0);
        chk("abort_outM", 32'(outM), 32'd0);
        chk("abort_instr_ready", 32'(instr_ready), 32'd0);
        chk("abort_pc", 32'(pc), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_a  = 16'h0000;
        m_d  = 16'h0000;
        m_pc = 15'h0000;
        @(negedge clk);
        chk("post_rst_pc", 32'(pc), 32'd0);
        chk("post_rst_A", 32'(addressM), 32'd0);
        chk("post_rst_D", 32'(alu_x), 32'd0);
        chk("post_rst_ready", 32'(instr_ready), 32'd1);
        chk("abort_mem_kept", 32'(dev_mem[ab_addr]), 32'(ab_data));
        @(posedge clk);
        #1;
        mon_en   = 1'b1;
        model_on = 1'b1;

        issue(16'h0003);
        issue(16'hEC10);
        issue(16'hE7C8);
        wait_idle();
        chk("final_doneq_empty", 32'(doneq.size()), 32'd0);
        chk("final_wrq_empty", 32'(wrq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
